// File: rtl/zq_axi_pkg.sv
// Shared AXI response/burst encodings and a constant-width helper for the
// zq AXI adapter blocks.
package zq_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/zq_id_fifo.sv
// Flop-based ID FIFO; exposes both slot indices so the adapter can use the
// write slot as the narrow core ID and check returns against the head slot.
module zq_id_fifo
  import zq_axi_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4,
  localparam int PW   = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o,
  output logic [PW-1:0]    wslot_o,
  output logic [PW-1:0]    rslot_o
);

  logic [PW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the slot bits match.
  assign full_o  = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign wslot_o = wptr_q[PW-1:0];
  assign rslot_o = rptr_q[PW-1:0];
  assign head_o  = mem_q[rptr_q[PW-1:0]];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[PW-1:0]] <= din_i;
  end

endmodule

// File: rtl/zq_axi_id_adapter.sv
// AXI3 upstream -> core slave adapter: narrows IDs to FIFO slot indices and
// restores them on B/R; gates W on AW credit. ZQ_AXI_ID_CHECK_EN adds o_err.
module zq_axi_id_adapter
  import zq_axi_pkg::*;
#(
  parameter int UP_ID_W  = 12,
  parameter int DN_ID_W  = 8,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int UP_LEN_W = 4,
  parameter int DN_LEN_W = 5,
  parameter int DEPTH    = 4
) (
  input  logic                clk_core,
  input  logic                rst_x,
  input  logic [UP_ID_W-1:0]  s_awid,
  input  logic [ADDR_W-1:0]   s_awaddr,
  input  logic [UP_LEN_W-1:0] s_awlen,
  input  logic [2:0]          s_awsize,
  input  logic [1:0]          s_awburst,
  input  logic                s_awvalid,
  output logic                s_awready,
  input  logic [UP_ID_W-1:0]  s_wid,
  input  logic [DATA_W-1:0]   s_wdata,
  input  logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_wlast,
  input  logic                s_wvalid,
  output logic                s_wready,
  output logic [UP_ID_W-1:0]  s_bid,
  output logic [1:0]          s_bresp,
  output logic                s_bvalid,
  input  logic                s_bready,
  input  logic [UP_ID_W-1:0]  s_arid,
  input  logic [ADDR_W-1:0]   s_araddr,
  input  logic [UP_LEN_W-1:0] s_arlen,
  input  logic [2:0]          s_arsize,
  input  logic [1:0]          s_arburst,
  input  logic                s_arvalid,
  output logic                s_arready,
  output logic [UP_ID_W-1:0]  s_rid,
  output logic [DATA_W-1:0]   s_rdata,
  output logic [1:0]          s_rresp,
  output logic                s_rlast,
  output logic                s_rvalid,
  input  logic                s_rready,
  output logic [DN_ID_W-1:0]  m_awid,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic [DN_LEN_W-1:0] m_awlen,
  output logic [2:0]          m_awsize,
  output logic [1:0]          m_awburst,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wlast,
  output logic                m_wvalid,
  input  logic                m_wready,
  input  logic [DN_ID_W-1:0]  m_bid,
  input  logic [1:0]          m_bresp,
  input  logic                m_bvalid,
  output logic                m_bready,
  output logic [DN_ID_W-1:0]  m_arid,
  output logic [ADDR_W-1:0]   m_araddr,
  output logic [DN_LEN_W-1:0] m_arlen,
  output logic [2:0]          m_arsize,
  output logic [1:0]          m_arburst,
  output logic                m_arvalid,
  input  logic                m_arready,
  input  logic [DN_ID_W-1:0]  m_rid,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [1:0]          m_rresp,
  input  logic                m_rlast,
  input  logic                m_rvalid,
  output logic                m_rready
`ifdef ZQ_AXI_ID_CHECK_EN
  ,output logic               o_err
`endif
);

  localparam int PW = clog2(DEPTH);

  logic               wf_full, wf_empty, rf_full, rf_empty;
  logic [UP_ID_W-1:0] wf_head, rf_head;
  logic [PW-1:0]      wf_wslot, wf_rslot, rf_wslot, rf_rslot;
  logic               aw_hs, wl_hs, b_hs, ar_hs, r_hs, rl_hs;
  logic [PW:0]        credit_q, credit_d;

  // ---------------- write side ----------------
  assign m_awvalid = s_awvalid & ~wf_full;
  assign s_awready = m_awready & ~wf_full;
  assign aw_hs     = s_awvalid & s_awready;
  assign m_awid    = DN_ID_W'(wf_wslot);
  assign m_awlen   = DN_LEN_W'(s_awlen);
  assign m_awaddr  = s_awaddr;
  assign m_awsize  = s_awsize;
  assign m_awburst = s_awburst;

  // Credit counts AWs whose W burst has not yet seen wlast.
  assign m_wvalid = s_wvalid & (credit_q != '0);
  assign s_wready = m_wready & (credit_q != '0);
  assign wl_hs    = s_wvalid & s_wready & s_wlast;
  assign m_wdata  = s_wdata;
  assign m_wstrb  = s_wstrb;
  assign m_wlast  = s_wlast;

  always_comb begin
    credit_d = credit_q;
    case ({aw_hs, wl_hs})
      2'b10:   credit_d = credit_q + 1'b1;
      2'b01:   credit_d = credit_q - 1'b1;
      default: credit_d = credit_q;
    endcase
  end

  always_ff @(posedge clk_core or negedge rst_x) begin
    if (!rst_x) credit_q <= '0;
    else        credit_q <= credit_d;
  end

  assign s_bvalid = m_bvalid & ~wf_empty;
  assign m_bready = s_bready & ~wf_empty;
  assign b_hs     = m_bvalid & m_bready;
  assign s_bid    = wf_head;

  zq_id_fifo #(.WIDTH(UP_ID_W), .DEPTH(DEPTH)) u_wfifo (
    .clk(clk_core), .rst_n(rst_x), .push_i(aw_hs), .din_i(s_awid), .pop_i(b_hs),
    .full_o(wf_full), .empty_o(wf_empty), .head_o(wf_head),
    .wslot_o(wf_wslot), .rslot_o(wf_rslot)
  );

  // ---------------- read side ----------------
  assign m_arvalid = s_arvalid & ~rf_full;
  assign s_arready = m_arready & ~rf_full;
  assign ar_hs     = s_arvalid & s_arready;
  assign m_arid    = DN_ID_W'(rf_wslot);
  assign m_arlen   = DN_LEN_W'(s_arlen);
  assign m_araddr  = s_araddr;
  assign m_arsize  = s_arsize;
  assign m_arburst = s_arburst;

  assign s_rvalid = m_rvalid & ~rf_empty;
  assign m_rready = s_rready & ~rf_empty;
  assign r_hs     = m_rvalid & m_rready;
  assign rl_hs    = r_hs & m_rlast;
  assign s_rid    = rf_head;
  assign s_rdata  = m_rdata;
  assign s_rlast  = m_rlast;

  zq_id_fifo #(.WIDTH(UP_ID_W), .DEPTH(DEPTH)) u_rfifo (
    .clk(clk_core), .rst_n(rst_x), .push_i(ar_hs), .din_i(s_arid), .pop_i(rl_hs),
    .full_o(rf_full), .empty_o(rf_empty), .head_o(rf_head),
    .wslot_o(rf_wslot), .rslot_o(rf_rslot)
  );

  logic unused_wid;
  assign unused_wid = ^s_wid;

`ifdef ZQ_AXI_ID_CHECK_EN
  logic b_mis, r_mis, err_q;

  // Returned core IDs must equal the slot at the head of their FIFO.
  assign b_mis   = (m_bid != DN_ID_W'(wf_rslot));
  assign r_mis   = (m_rid != DN_ID_W'(rf_rslot));
  assign s_bresp = b_mis ? RESP_SLVERR : m_bresp;
  assign s_rresp = r_mis ? RESP_SLVERR : m_rresp;
  assign o_err   = err_q;

  always_ff @(posedge clk_core or negedge rst_x) begin
    if (!rst_x)                                err_q <= 1'b0;
    else if ((b_hs & b_mis) | (r_hs & r_mis))  err_q <= 1'b1;
  end
`else
  logic unused_ids;
  assign unused_ids = ^{m_bid, m_rid, wf_rslot, rf_rslot};
  assign s_bresp    = m_bresp;
  assign s_rresp    = m_rresp;
`endif

endmodule

// File: tb/tb_zq_axi_id_adapter.sv
// Directed + random bench for zq_axi_id_adapter against a queue-based model
// of outstanding IDs, W credit and slot numbering.
module tb_zq_axi_id_adapter;
  import zq_axi_pkg::*;

  localparam int DEPTH = 4;

  // step() control bits: 11 awv,10 awr,9 wv,8 wr,7 wl,6 bv,5 br,4 arv,3 arr,2 rv,1 rr,0 rl
  localparam bit [11:0] AW = 12'hC00, W = 12'h300, WL = 12'h380, B = 12'h060;
  localparam bit [11:0] AR = 12'h018, R = 12'h006, RL = 12'h007, IDLE = 12'h000;

  logic clk_core = 1'b0;
  logic rst_x    = 1'b0;
  always #5 clk_core = ~clk_core;

  logic [11:0] s_awid, s_wid, s_bid, s_arid, s_rid;
  logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata, m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [3:0]  s_awlen, s_arlen, s_wstrb, m_wstrb;
  logic [2:0]  s_awsize, s_arsize, m_awsize, m_arsize;
  logic [1:0]  s_awburst, s_arburst, m_awburst, m_arburst, s_bresp, s_rresp, m_bresp, m_rresp;
  logic        s_awvalid, s_awready, s_wlast, s_wvalid, s_wready, s_bvalid, s_bready;
  logic        s_arvalid, s_arready, s_rlast, s_rvalid, s_rready;
  logic [7:0]  m_awid, m_bid, m_arid, m_rid;
  logic [4:0]  m_awlen, m_arlen;
  logic        m_awvalid, m_awready, m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;
  logic        m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;
`ifdef ZQ_AXI_ID_CHECK_EN
  logic        o_err;
`endif

  zq_axi_id_adapter dut (
    .clk_core(clk_core), .rst_x(rst_x),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
    .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wid(s_wid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awburst(m_awburst), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready)
`ifdef ZQ_AXI_ID_CHECK_EN
    ,.o_err(o_err)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: outstanding upstream IDs in issue order, open W bursts,
  // and running push/pop counts whose low bits are the expected core IDs.
  logic [11:0] wq[$];
  logic [11:0] rq[$];
  int credit, wpush, wpop, rpush, rpop;
  bit err_m, force_bid;
  logic [11:0] awid_g, arid_g;
  logic [3:0]  awlen_g, arlen_g;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit [11:0] c, input logic [1:0] bresp = RESP_OKAY,
                      input logic [1:0] rresp = RESP_OKAY);
    bit awv, awr, wv, wr, wl, bv, br, arv, arr, rv, rr, rl;
    bit aw_ok, ar_ok, w_ok, b_ok, r_ok;
    logic [31:0] addr, raddr, wd, rd;
    logic [1:0] xb;
    {awv, awr, wv, wr, wl, bv, br, arv, arr, rv, rr, rl} = c;
    @(negedge clk_core);
    addr = $urandom; raddr = $urandom; wd = $urandom; rd = $urandom;
    s_awvalid = awv; s_awid = awid_g; s_awaddr = addr; s_awlen = awlen_g;
    s_awsize = 3'd2; s_awburst = BURST_INCR; m_awready = awr;
    s_wvalid = wv; s_wid = 12'($urandom); s_wdata = wd; s_wstrb = 4'hF; s_wlast = wl; m_wready = wr;
    m_bvalid = bv; m_bresp = bresp; s_bready = br;
    m_bid = 8'(wpop % DEPTH) + (force_bid ? 8'd2 : 8'd0);
    s_arvalid = arv; s_arid = arid_g; s_araddr = raddr; s_arlen = arlen_g;
    s_arsize = 3'd2; s_arburst = BURST_WRAP; m_arready = arr;
    m_rvalid = rv; m_rid = 8'(rpop % DEPTH); m_rdata = rd; m_rresp = rresp; m_rlast = rl;
    s_rready = rr;
    #1;
    aw_ok = wq.size() < DEPTH;
    ar_ok = rq.size() < DEPTH;
    w_ok  = credit != 0;
    b_ok  = wq.size() != 0;
    r_ok  = rq.size() != 0;
    chk("m_awvalid", m_awvalid, awv & aw_ok);
    chk("s_awready", s_awready, awr & aw_ok);
    if (awv && aw_ok) begin
      chk("m_awid", m_awid, 64'(wpush % DEPTH));
      chk("m_awlen", m_awlen, awlen_g);
      chk("m_awaddr", m_awaddr, addr);
    end
    chk("m_wvalid", m_wvalid, wv & w_ok);
    chk("s_wready", s_wready, wr & w_ok);
    if (wv) chk("m_wdata", m_wdata, wd);
    chk("s_bvalid", s_bvalid, bv & b_ok);
    chk("m_bready", m_bready, br & b_ok);
    if (bv && b_ok) begin
      xb = bresp;
`ifdef ZQ_AXI_ID_CHECK_EN
      if (force_bid) xb = RESP_SLVERR;
`endif
      chk("s_bid", s_bid, wq[0]);
      chk("s_bresp", s_bresp, xb);
    end
    chk("m_arvalid", m_arvalid, arv & ar_ok);
    chk("s_arready", s_arready, arr & ar_ok);
    if (arv && ar_ok) begin
      chk("m_arid", m_arid, 64'(rpush % DEPTH));
      chk("m_arlen", m_arlen, arlen_g);
    end
    chk("s_rvalid", s_rvalid, rv & r_ok);
    chk("m_rready", m_rready, rr & r_ok);
    if (rv && r_ok) begin
      chk("s_rid", s_rid, rq[0]);
      chk("s_rdata", s_rdata, rd);
      chk("s_rresp", s_rresp, rresp);
      chk("s_rlast", s_rlast, rl);
    end
`ifdef ZQ_AXI_ID_CHECK_EN
    chk("o_err", o_err, err_m);
`endif
    @(posedge clk_core);
    if (rst_x) begin
      if (wv && wr && w_ok && wl) credit--;
      if (awv && awr && aw_ok) begin wq.push_back(awid_g); credit++; wpush++; end
      if (bv && br && b_ok) begin
        if (force_bid) err_m = 1'b1;
        void'(wq.pop_front()); wpop++;
      end
      if (arv && arr && ar_ok) begin rq.push_back(arid_g); rpush++; end
      if (rv && rr && r_ok && rl) begin void'(rq.pop_front()); rpop++; end
    end
  endtask

  task automatic do_reset();
    @(negedge clk_core);
    rst_x = 1'b0;
    wq.delete(); rq.delete();
    credit = 0; wpush = 0; wpop = 0; rpush = 0; rpop = 0;
    err_m = 1'b0; force_bid = 1'b0;
    // W/B/R valid+ready held high: empty FIFOs and zero credit must still block them.
    step(W | WL | B | R | RL);
    @(negedge clk_core);
    rst_x = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [11:0] c;
    awid_g = '0; arid_g = '0; awlen_g = '0; arlen_g = '0;
    do_reset();

    // single write burst, 4 beats
    awid_g = 12'hA5C; awlen_g = 4'd3;
    step(AW);
    step(W); step(W); step(W); step(WL);
    step(B, RESP_OKAY);
    step(B);

    // W offered before its AW
    do_reset();
    awid_g = 12'h3C3; awlen_g = 4'd1;
    step(W); step(W); step(W);
    step(AW | W);
    step(W); step(WL);
    step(W);
    step(B, RESP_EXOKAY);

    // fill to DEPTH, 5th AW stalls; pop at full does not admit it that cycle
    do_reset();
    awlen_g = 4'd0;
    for (int i = 0; i < DEPTH; i++) begin
      awid_g = 12'h100 + 12'(i);
      step(AW);
    end
    awid_g = 12'h104;
    step(AW);
    step(AW | WL);
    step(AW | B, RESP_DECERR);
    step(AW);
    for (int i = 0; i < DEPTH; i++) step(WL);
    for (int i = 0; i <= DEPTH; i++) step(B);

    // reads, ID held across a 2-beat burst
    arid_g = 12'h001; arlen_g = 4'd1; step(AR);
    arid_g = 12'hFFF; arlen_g = 4'd0; step(AR);
    step(R); step(RL); step(RL, RESP_OKAY, RESP_SLVERR);
    step(RL);

`ifdef ZQ_AXI_ID_CHECK_EN
    do_reset();
    awid_g = 12'h777; awlen_g = 4'd0;
    step(AW); step(WL);
    force_bid = 1'b1;
    step(B);
    force_bid = 1'b0;
    step(IDLE); step(IDLE);
    do_reset();
`endif

    // randomized traffic; B only returned for writes whose data is complete
    for (int i = 0; i < 400; i++) begin
      c = 12'($urandom);
      if (wq.size() <= credit) c[6] = 1'b0;
      awid_g = 12'($urandom); arid_g = 12'($urandom);
      awlen_g = 4'($urandom); arlen_g = 4'($urandom);
      step(c, 2'($urandom), 2'($urandom));
    end

    // reset with traffic in flight, then check everything is idle again
    do_reset();
    step(W | B | R);
    awid_g = 12'h5A5;
    step(AW | W);
    step(WL);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
